threshold_integrator: RTL



---
 rtl/threshold_integrator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/threshold_integrator.sv
// Tumbling-window magnitude integrator: sums |sample| over integ_window accepted
// samples and latches a sticky fault if the sum ever exceeds thresh * window.
module threshold_integrator #(
  parameter int WIDTH_WIN = 32,
  parameter int WIDTH_THR = 15
) (
  input  logic                 spi_clk,
  input  logic                 rst,
  input  logic [WIDTH_THR-1:0] integ_thresh_avg,
  input  logic [WIDTH_WIN-1:0] integ_window,
  input  logic                 integ_en,
  input  logic                 spi_en,
  input  logic                 sample_valid,
  input  logic signed [15:0]   sample,
  output logic                 running,
  output logic                 window_done,
  output logic                 over_thresh,
  output logic                 err_window
);

  // state | meaning
  // IDLE  | cleared, waiting for both enables
  // SETUP | one cycle: latch limit and window length
  // RUN   | accumulating magnitudes
  // FAULT | sum exceeded limit, held until rst
  // ERR   | zero window requested, held until rst
  typedef enum logic [2:0] {IDLE, SETUP, RUN, FAULT, ERR} state_t;

  localparam int WIDTH_SUM = WIDTH_WIN + WIDTH_THR;

  state_t               state, state_n;
  logic [WIDTH_SUM-1:0] sum, sum_n, nsum;
  logic [WIDTH_SUM-1:0] limit, limit_n;
  logic [WIDTH_WIN-1:0] count, count_n, ncount;
  logic [WIDTH_WIN-1:0] win_q, win_n;
  logic [15:0]          neg;
  logic [14:0]          mag;
  logic                 en;
  logic                 done_n;

  assign en  = spi_en & integ_en;
  assign neg = -sample;

  // -32768 has no positive counterpart in 16 bits, so it saturates
  always_comb begin
    if (sample == 16'sh8000)
      mag = 15'h7fff;
    else if (sample[15])
      mag = neg[14:0];
    else
      mag = sample[14:0];
  end

  assign nsum   = sum + WIDTH_SUM'(mag);
  assign ncount = count + 1'b1;

  always_comb begin
    state_n = state;
    sum_n   = sum;
    count_n = count;
    limit_n = limit;
    win_n   = win_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        sum_n   = '0;
        count_n = '0;
        if (en)
          state_n = SETUP;
      end
      SETUP: begin
        limit_n = WIDTH_SUM'(integ_thresh_avg) * WIDTH_SUM'(integ_window);
        win_n   = integ_window;
        if (!en)
          state_n = IDLE;
        else if (integ_window == '0)
          state_n = ERR;
        else
          state_n = RUN;
      end
      RUN: begin
        if (!en) begin
          state_n = IDLE;
          sum_n   = '0;
          count_n = '0;
        end else if (sample_valid) begin
          // overflow takes priority over window completion on the same sample
          if (nsum > limit) begin
            state_n = FAULT;
          end else if (ncount == win_q) begin
            done_n  = 1'b1;
            sum_n   = '0;
            count_n = '0;
          end else begin
            sum_n   = nsum;
            count_n = ncount;
          end
        end
      end
      FAULT: state_n = FAULT;
      ERR:   state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sum         <= '0;
      count       <= '0;
      limit       <= '0;
      win_q       <= '0;
      running     <= 1'b0;
      window_done <= 1'b0;
      over_thresh <= 1'b0;
      err_window  <= 1'b0;
    end else begin
      state       <= state_n;
      sum         <= sum_n;
      count       <= count_n;
      limit       <= limit_n;
      win_q       <= win_n;
      running     <= (state_n == RUN);
      window_done <= done_n;
      over_thresh <= (state_n == FAULT);
      err_window  <= (state_n == ERR);
    end
  end

endmodule
